// File: rtl/knight_sprite_pkg.sv
// Shared types and raster constants for the knight sprite address generator.
package knight_sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } anim_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int VBLANK_Y = 480;

endpackage

// File: rtl/knight_anim_fsm.sv
// Animation sequencer: steps frame_idx once every FRAME_HOLD vblank ticks.
//
// state | meaning
// IDLE  | after reset; frame 0, no advance
// PLAY  | counting vblank ticks, advancing frames (wraps if loop=1)
// HOLD  | non-looping run reached its last frame; frozen until start
module knight_anim_fsm
    import knight_sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    parameter int FIDX_W     = 2
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              vblank_tick,
    input  logic              start,
    input  logic              loop,
    output logic [FIDX_W-1:0] frame_idx,
    output logic              anim_done
);

    localparam int                 HCNT_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HCNT_W-1:0]  HOLD_LAST  = HCNT_W'(FRAME_HOLD - 1);
    localparam logic [HCNT_W-1:0]  HCNT_ONE   = HCNT_W'(1);
    localparam logic [FIDX_W-1:0]  FRAME_LAST = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [FIDX_W-1:0]  FRAME_ONE  = FIDX_W'(1);

    anim_state_t       r_state;
    logic [HCNT_W-1:0] r_hold_cnt;
    logic [FIDX_W-1:0] r_frame_idx;
    logic              r_anim_done;
    logic [FIDX_W-1:0] w_frame_inc;

    assign w_frame_inc = r_frame_idx + FRAME_ONE;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_frame_idx <= '0;
            r_anim_done <= 1'b0;
        end else begin
            r_anim_done <= 1'b0;
            // start overrides any advance that lands on the same tick
            if (start) begin
                r_state     <= PLAY;
                r_hold_cnt  <= '0;
                r_frame_idx <= '0;
            end else if (vblank_tick && r_state == PLAY) begin
                if (r_hold_cnt == HOLD_LAST) begin
                    r_hold_cnt <= '0;
                    if (r_frame_idx == FRAME_LAST) begin
                        if (loop) begin
                            r_frame_idx <= '0;
                        end else begin
                            r_state     <= HOLD;
                            r_anim_done <= 1'b1;
                        end
                    end else begin
                        r_frame_idx <= w_frame_inc;
                        if (!loop && w_frame_inc == FRAME_LAST) begin
                            r_state     <= HOLD;
                            r_anim_done <= 1'b1;
                        end
                    end
                end else begin
                    r_hold_cnt <= r_hold_cnt + HCNT_ONE;
                end
            end
        end
    end

    assign frame_idx = r_frame_idx;
    assign anim_done = r_anim_done;

endmodule

// File: rtl/knight_sprite_addr_gen.sv
// Per-pixel ROM address generator for an animated, optionally mirrored knight sprite.
// Position/flip are latched at the vblank tick; addresses come out of a 2-stage pipeline.
module knight_sprite_addr_gen
    import knight_sprite_pkg::*;
#(
    parameter int SPRITE_W   = 50,
    parameter int SPRITE_H   = 64,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    parameter int ADDR_W     = 14
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [9:0]           pos_x,
    input  logic [9:0]           pos_y,
    input  logic                 flip,
    input  logic                 start,
    input  logic                 loop,
    output logic [ADDR_W-1:0]    rom_address,
    output logic                 addr_valid,
    output logic                 pix_valid,
    output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frame_idx,
    output logic                 anim_done
);

    localparam int          FIDX_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam logic [9:0]  SW10     = 10'(SPRITE_W);
    localparam logic [9:0]  SH10     = 10'(SPRITE_H);
    localparam logic [9:0]  TICK_Y   = 10'(VBLANK_Y);
    localparam logic [31:0] FRAME_SZ = 32'(SPRITE_W * SPRITE_H);

    logic              w_vblank_tick;
    logic [9:0]        r_lat_x;
    logic [9:0]        r_lat_y;
    logic              r_lat_flip;

    logic signed [10:0] w_rel_x;
    logic signed [10:0] w_rel_y;
    logic               w_hit;

    logic              r_s1_hit;
    logic [9:0]        r_s1_row;
    logic [9:0]        r_s1_col;

    logic [ADDR_W-1:0] r_rom_address;
    logic              r_addr_valid;
    logic              r_pix_valid;
    logic [FIDX_W-1:0] w_frame_idx;

    assign w_vblank_tick = (DrawX == 10'd0) && (DrawY == TICK_Y);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_lat_x    <= '0;
            r_lat_y    <= '0;
            r_lat_flip <= 1'b0;
        end else if (w_vblank_tick) begin
            r_lat_x    <= pos_x;
            r_lat_y    <= pos_y;
            r_lat_flip <= flip;
        end
    end

    knight_anim_fsm #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .FIDX_W     (FIDX_W)
    ) u_anim_fsm (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .vblank_tick (w_vblank_tick),
        .start       (start),
        .loop        (loop),
        .frame_idx   (w_frame_idx),
        .anim_done   (anim_done)
    );

    // Sign bit of the 11-bit difference rejects pixels left of / above the box.
    assign w_rel_x = signed'({1'b0, DrawX}) - signed'({1'b0, r_lat_x});
    assign w_rel_y = signed'({1'b0, DrawY}) - signed'({1'b0, r_lat_y});
    assign w_hit   = !w_rel_x[10] && (w_rel_x[9:0] < SW10) &&
                     !w_rel_y[10] && (w_rel_y[9:0] < SH10);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_s1_hit <= 1'b0;
            r_s1_row <= '0;
            r_s1_col <= '0;
        end else begin
            r_s1_hit <= w_hit;
            r_s1_row <= w_rel_y[9:0];
            r_s1_col <= r_lat_flip ? (SW10 - 10'd1 - w_rel_x[9:0]) : w_rel_x[9:0];
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_rom_address <= '0;
            r_addr_valid  <= 1'b0;
            r_pix_valid   <= 1'b0;
        end else begin
            r_addr_valid <= r_s1_hit;
            r_pix_valid  <= r_addr_valid;
            if (r_s1_hit) begin
                r_rom_address <= ADDR_W'(32'(w_frame_idx) * FRAME_SZ
                                         + 32'(r_s1_row) * 32'(SPRITE_W)
                                         + 32'(r_s1_col));
            end else begin
                r_rom_address <= '0;
            end
        end
    end

    assign rom_address = r_rom_address;
    assign addr_valid  = r_addr_valid;
    assign pix_valid   = r_pix_valid;
    assign frame_idx   = w_frame_idx;

endmodule

// File: tb/tb_knight_sprite_addr_gen.sv
// Directed bench for knight_sprite_addr_gen: addressing, flip, clipping, latching and animation.
module tb_knight_sprite_addr_gen;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        flip, start, loop;
    logic [13:0] rom_address;
    logic        addr_valid, pix_valid, anim_done;
    logic [1:0]  frame_idx;

    int total = 0;
    int bad   = 0;

    knight_sprite_addr_gen dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip        (flip),
        .start       (start),
        .loop        (loop),
        .rom_address (rom_address),
        .addr_valid  (addr_valid),
        .pix_valid   (pix_valid),
        .frame_idx   (frame_idx),
        .anim_done   (anim_done)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic step(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic vblank();
        DrawX = 10'd0;
        DrawY = 10'd480;
        step(1);
        DrawX = 10'd700;
        DrawY = 10'd500;
    endtask

    task automatic pixel(input int x, input int y, input string tag,
                         input int exp_valid, input int exp_addr);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step(2);
        check({tag, "_valid"}, 32'(addr_valid), 32'(exp_valid));
        check({tag, "_addr"},  32'(rom_address), 32'(exp_addr));
    endtask

    initial begin
        reset_n = 1'b0;
        DrawX = 10'd110; DrawY = 10'd205;
        pos_x = 10'd100; pos_y = 10'd200;
        flip = 1'b0; start = 1'b0; loop = 1'b0;
        step(3);
        check("rst_addr", 32'(rom_address), 0);
        check("rst_valid", 32'(addr_valid), 0);
        check("rst_pix", 32'(pix_valid), 0);
        check("rst_frame", 32'(frame_idx), 0);
        check("rst_done", 32'(anim_done), 0);

        reset_n = 1'b1;
        pixel(110, 205, "idle_miss", 0, 0);
        pixel(3, 2, "idle_origin", 1, 103);

        vblank();
        pixel(110, 205, "hit", 1, 260);
        step(1);
        check("hit_pix", 32'(pix_valid), 1);
        pixel(99, 205, "neg_x", 0, 0);
        pixel(110, 199, "neg_y", 0, 0);
        pixel(149, 263, "corner", 1, 63 * 50 + 49);
        pixel(110, 264, "below", 0, 0);
        step(1);
        check("below_pix", 32'(pix_valid), 0);

        flip = 1'b1;
        vblank();
        pixel(110, 205, "flip_hit", 1, 289);
        pixel(150, 205, "flip_edge", 0, 0);
        pixel(149, 205, "flip_last", 1, 250);
        pixel(100, 205, "flip_first", 1, 299);

        flip = 1'b0;
        loop = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("loop_start", 32'(frame_idx), 0);
        for (int k = 1; k <= 24; k++) begin
            vblank();
            check($sformatf("loop_frame_t%0d", k), 32'(frame_idx), 32'((k / 6) % 4));
            check($sformatf("loop_done_t%0d", k), 32'(anim_done), 0);
            if (k == 12) pixel(110, 205, "frame2", 1, 6660);
        end

        loop = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("one_start", 32'(frame_idx), 0);
        for (int k = 1; k <= 18; k++) begin
            vblank();
            check($sformatf("one_frame_t%0d", k), 32'(frame_idx), 32'(k / 6));
            check($sformatf("one_done_t%0d", k), 32'(anim_done), (k == 18) ? 1 : 0);
        end
        step(1);
        check("one_done_clear", 32'(anim_done), 0);
        for (int k = 1; k <= 30; k++) begin
            vblank();
            check($sformatf("hold_frame_t%0d", k), 32'(frame_idx), 3);
            check($sformatf("hold_done_t%0d", k), 32'(anim_done), 0);
        end

        DrawX = 10'd0; DrawY = 10'd480; start = 1'b1;
        step(1);
        start = 1'b0; DrawX = 10'd700; DrawY = 10'd500;
        check("start_on_tick", 32'(frame_idx), 0);
        for (int k = 1; k <= 6; k++) begin
            vblank();
            if (k == 5) check("restart_t5", 32'(frame_idx), 0);
        end
        check("restart_t6", 32'(frame_idx), 1);

        DrawX = 10'd110; DrawY = 10'd205;
        step(3);
        check("pre_rst_valid", 32'(addr_valid), 1);
        reset_n = 1'b0;
        step(1);
        check("mid_rst_frame", 32'(frame_idx), 0);
        check("mid_rst_valid", 32'(addr_valid), 0);
        check("mid_rst_addr", 32'(rom_address), 0);
        check("mid_rst_pix", 32'(pix_valid), 0);
        reset_n = 1'b1;
        pixel(110, 205, "post_rst", 0, 0);

        pos_x = 10'd620; pos_y = 10'd0;
        vblank();
        pixel(619, 10, "clip_left", 0, 0);
        pixel(620, 10, "clip_first", 1, 500);
        pixel(639, 10, "clip_last", 1, 519);
        pos_x = 10'd0;
        pixel(620, 10, "latch_hold", 1, 500);
        pixel(5, 10, "latch_old_miss", 0, 0);
        vblank();
        pixel(620, 10, "latch_new_miss", 0, 0);
        pixel(5, 10, "latch_new_hit", 1, 505);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
